// File: rtl/key_expansion_ctrl.sv
// AES-128 key-schedule sequencer: emits round keys 0..10 with valid/ready handshake,
// using an external shared S-box word unit through sub_in/sub_out.
module key_expansion_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done,
    output logic [31:0]  sub_in,
    input  logic [31:0]  sub_out
);

    typedef enum logic [1:0] {StIdle, StEmit, StSub} state_e;

    localparam logic [3:0] LastRound = 4'd10;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         handshake;
    logic [31:0]  t_word;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [7:0]   rcon_next;

    assign handshake = (state_q == StEmit) && rk_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (rk_ready) begin
                    state_d = (idx_q == LastRound) ? StIdle : StSub;
                end
            end
            StSub: begin
                state_d = StEmit;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        rk_valid = (state_q == StEmit);
    end

    // One round of the schedule; sub_out is only meaningful while in StSub.
    always_comb begin
        t_word    = sub_out ^ {rcon_q, 24'h000000};
        w0_n      = key_q[127:96] ^ t_word;
        w1_n      = key_q[95:64] ^ w0_n;
        w2_n      = key_q[63:32] ^ w1_n;
        w3_n      = key_q[31:0] ^ w2_n;
        rcon_next = rcon_q[7] ? ({rcon_q[6:0], 1'b0} ^ 8'h1b) : {rcon_q[6:0], 1'b0};
    end

    always_comb begin
        key_d  = key_q;
        idx_d  = idx_q;
        rcon_d = rcon_q;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d  = key_in;
                    idx_d  = 4'd0;
                    rcon_d = 8'h01;
                    busy_d = 1'b1;
                end
            end
            StEmit: begin
                if (handshake && (idx_q == LastRound)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            StSub: begin
                key_d  = {w0_n, w1_n, w2_n, w3_n};
                idx_d  = idx_q + 4'd1;
                rcon_d = rcon_next;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            idx_q  <= 4'd0;
            rcon_q <= 8'h01;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            key_q  <= key_d;
            idx_q  <= idx_d;
            rcon_q <= rcon_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign rk_out   = key_q;
    assign rk_index = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sub_in   = {key_q[23:0], key_q[31:24]};

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench for key_expansion_ctrl: FIPS-197 key schedule reference model,
// S-box built from GF(2^8) arithmetic, directed and randomized handshake scenarios.
module tb_key_expansion_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;

    key_expansion_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_index (rk_index),
        .busy     (busy),
        .done     (done),
        .sub_in   (sub_in),
        .sub_out  (sub_out)
    );

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int n_checks = 0;
    int n_fail   = 0;
    bit sim_on   = 1'b0;
    bit sbox_done = 1'b0;

    logic [7:0] sbox [256];
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Textbook FIPS-197 expansion into 44 words, returning round key n.
    function automatic logic [127:0] rk_of(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 4*n + 4; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword(rotword(t)) ^ {rcon_tab[i/4 - 1], 24'h000000};
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Shared S-box unit that the parent would provide.
    always @(sub_in or sbox_done) sub_out = subword(sub_in);

    // Handshake-level model of what the consumer must observe.
    logic [127:0] m_key    = '0;
    bit           m_loaded = 1'b0;
    bit           m_valid  = 1'b0;
    bit           m_busy   = 1'b0;
    bit           m_done   = 1'b0;
    bit           m_sub    = 1'b0;
    int           m_idx    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_key <= '0; m_loaded <= 1'b0; m_valid <= 1'b0; m_busy <= 1'b0;
            m_done <= 1'b0; m_sub <= 1'b0; m_idx <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_key <= key_in; m_loaded <= 1'b1; m_idx <= 0;
                    m_valid <= 1'b1; m_busy <= 1'b1;
                end
            end else if (m_valid) begin
                if (rk_ready) begin
                    m_valid <= 1'b0;
                    if (m_idx == 10) begin
                        m_busy <= 1'b0; m_done <= 1'b1;
                    end else begin
                        m_sub <= 1'b1;
                    end
                end
            end else if (m_sub) begin
                m_sub <= 1'b0; m_valid <= 1'b1; m_idx <= m_idx + 1;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        logic [127:0] exp_reg;
        if (sim_on) begin
            exp_reg = m_loaded ? rk_of(m_key, m_idx) : 128'h0;
            chk("rk_valid", rk_valid, m_valid);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("rk_index", rk_index, m_idx);
            chk("rk_out", rk_out, exp_reg);
            chk("sub_in", sub_in, rotword(exp_reg[31:0]));
            if (m_sub) chk("rcon", dut.rcon_q, rcon_tab[m_idx]);
        end
    end

    // pin: 0 none, 1 FIPS literal checks, 2 zero-key literal checks
    task automatic run_key(input logic [127:0] key, input int pin, input int stall_idx,
                           input bit restart, input bit rand_mode, input bit do_reset,
                           input bit b2b, input int exp_done);
        bit           ended;
        bit           stalled;
        int           stall_left;
        logic [127:0] hold_rk;
        logic [3:0]   hold_idx;
        ended = 1'b0;
        stalled = 1'b0;
        stall_left = 0;
        hold_rk = '0;
        hold_idx = '0;
        if (!b2b) @(negedge clk);
        key_in = key;
        start = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 400 && !ended; n++) begin
            @(negedge clk);
            if (pin == 1) begin
                if (n == 1) chk("fips_rk0", rk_out, FipsKey);
                if (n == 2) begin
                    chk("fips_sub_in", sub_in, 32'hcf4f3c09);
                    chk("fips_sub_out", sub_out, 32'h8a84eb01);
                    chk("fips_rcon0", dut.rcon_q, 8'h01);
                end
                if (n == 3) chk("fips_rk1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
                if (n == 21) chk("fips_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            end
            if (pin == 2) begin
                if (n == 1) begin
                    chk("zero_rk0_valid", rk_valid, 1'b1);
                    chk("zero_rk0", rk_out, 128'h0);
                end
                if (n == 3) chk("zero_rk1", rk_out, 128'h62636363626363636263636362636363);
                if (n == 21) chk("zero_rk10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
            end
            if (done) begin
                if (exp_done > 0) chk("done_cycle", n, exp_done);
                start = 1'b0;
                rk_ready = 1'b1;
                ended = 1'b1;
            end else if (do_reset && rk_valid && rk_index == 4'd5) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_rk_valid", rk_valid, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_rk_index", rk_index, 4'd0);
                chk("rst_sub_in", sub_in, 32'h0);
                chk("rst_done", done, 1'b0);
                @(negedge clk);
                rst = 1'b0;
                ended = 1'b1;
            end else begin
                if (stall_left > 0) begin
                    chk("stall_rk_out", rk_out, hold_rk);
                    chk("stall_rk_index", rk_index, hold_idx);
                    stall_left--;
                    if (stall_left == 0) rk_ready = 1'b1;
                end else if (stall_idx >= 0 && !stalled && rk_valid && rk_index == stall_idx) begin
                    rk_ready = 1'b0;
                    stall_left = 5;
                    stalled = 1'b1;
                    hold_rk = rk_out;
                    hold_idx = rk_index;
                end
                if (restart) begin
                    start = (n == 4 || n == 10);
                    key_in = ~key;
                end
                if (rand_mode) begin
                    rk_ready = ($urandom_range(0, 3) != 0);
                    start = ($urandom_range(0, 7) == 0);
                    key_in = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        if (!ended) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done within 400 cycles, got busy=%0b expected done=1", busy);
            start = 1'b0;
            rk_ready = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        key_in = '0;
        rk_ready = 1'b1;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        sbox_done = 1'b1;

        // Pin the reference model to published values.
        chk("model_sbox_00", sbox[0], 8'h63);
        chk("model_sbox_53", sbox[8'h53], 8'hed);
        chk("model_fips_rk1", rk_of(FipsKey, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_fips_rk10", rk_of(FipsKey, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_zero_rk1", rk_of(128'h0, 1), 128'h62636363626363636263636362636363);
        chk("model_zero_rk10", rk_of(128'h0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rk_valid", rk_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_rk_index", rk_index, 4'd0);
        chk("reset_rk_out", rk_out, 128'h0);
        chk("reset_sub_in", sub_in, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sim_on = 1'b1;

        run_key(FipsKey, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 22);
        run_key(128'h0, 2, -1, 1'b0, 1'b0, 1'b0, 1'b0, 22);
        run_key(FipsKey, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 27);
        run_key(FipsKey, 1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 22);
        run_key(FipsKey, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 22);
        run_key(128'h0, 2, -1, 1'b0, 1'b0, 1'b0, 1'b1, 22);
        run_key(FipsKey, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_key(FipsKey, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 22);
        for (int r = 0; r < 6; r++) begin
            run_key({$urandom, $urandom, $urandom, $urandom}, 0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        end
        repeat (3) @(negedge clk);
        sim_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
